// File: rtl/alu_pkg.sv
// Shared opcode, compare-path select and FSM state encodings for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [1:0] OPC_AND = 2'b00;
    localparam logic [1:0] OPC_OR  = 2'b01;
    localparam logic [1:0] OPC_ADD = 2'b10;
    localparam logic [1:0] OPC_CMP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Opcode to {SUBctr, OPctr, OVctr, SIGctr, illegal} decoder.
// Latency: combinational. Backpressure: none (no state).
// Opcode 1000 is legal only when ALU_MUL_EN is defined.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [3:0] ALUctr,
    output logic       SUBctr,
    output logic [1:0] OPctr,
    output logic       OVctr,
    output logic       SIGctr,
    output logic       illegal
);

    always_comb begin
        SUBctr = ALUctr[2] | (ALUctr == OP_SLTU);
        OPctr  = ALUctr[1:0];
        OVctr  = ALUctr[1] & ~ALUctr[0] & ~ALUctr[3];
        SIGctr = ALUctr[2] & ALUctr[0];
        case (ALUctr)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU: illegal = 1'b0;
`ifdef ALU_MUL_EN
            OP_MUL: illegal = 1'b0;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: logic/add/sub/compare in 1 cycle, optional shift-add MUL (ALU_MUL_EN) in WIDTH+1 cycles.
// Latency: out_valid 1 cycle after accept (WIDTH+1 for MUL). Backpressure: result held in DONE until
// out_ready; in_ready low from accept until handoff, so at most one op every 2 cycles.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    state_t state;

    logic             sub_ctr;
    logic [1:0]       op_ctr;
    logic             ov_ctr;
    logic             sig_ctr;
    logic             dec_illegal;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ov_flag;
    logic             ov_true;
    logic             lt;
    logic [WIDTH-1:0] alu_res;

    alu_ctrl_dec u_dec (
        .ALUctr  (ALUctr),
        .SUBctr  (sub_ctr),
        .OPctr   (op_ctr),
        .OVctr   (ov_ctr),
        .SIGctr  (sig_ctr),
        .illegal (dec_illegal)
    );

    // The Overflow flag compares against the negated operand ~B+1; the SLT sign correction uses the
    // true adder-input overflow so that B == most-negative still orders correctly.
    always_comb begin
        b_eff          = sub_ctr ? ~B : B;
        b_neg          = sub_ctr ? (~B + WIDTH'(1)) : B;
        {carry, sum}   = {1'b0, A} + {1'b0, b_eff} + (WIDTH+1)'(sub_ctr);
        ov_flag        = ov_ctr & ~dec_illegal & (A[WIDTH-1] == b_neg[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
        ov_true        = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
        lt             = sig_ctr ? (sum[WIDTH-1] ^ ov_true) : ~carry;
        case (op_ctr)
            OPC_AND: alu_res = A & B;
            OPC_OR:  alu_res = A | B;
            OPC_ADD: alu_res = sum;
            default: alu_res = {{(WIDTH-1){1'b0}}, lt};
        endcase
        if (dec_illegal)
            alu_res = '0;
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_nxt;
    logic             is_mul;

    always_comb begin
        is_mul  = (ALUctr == OP_MUL);
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_MUL_EN
                        if (is_mul) begin
                            acc    <= '0;
                            mcand  <= A;
                            mplier <= B;
                            cnt    <= '0;
                            state  <= ST_MUL;
                        end else
`endif
                        begin
                            Result    <= alu_res;
                            Zero      <= (alu_res == '0);
                            Overflow  <= ov_flag;
                            Illegal   <= dec_illegal;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        Result    <= acc_nxt;
                        Zero      <= (acc_nxt == '0);
                        Overflow  <= 1'b0;
                        Illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at WIDTH=8; MUL expectations follow ALU_MUL_EN.
module tb_alu_seq_unit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUctr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;
    logic             Illegal;

    int checks;
    int failures;

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctr    (ALUctr),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op, hold until accepted, then count negedges until out_valid (1 = next cycle).
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit busy_ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ALUctr   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b0 || Overflow !== 1'b0 || Illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_out Result=%h Z=%b V=%b I=%b required 00/0/0/0", Result, Zero, Overflow, Illegal);
        end
    endtask

    task automatic test_add();
        int lat;
        bit busy_ok;
        out_ready = 1'b1;
        issue(4'b0010, 8'h7F, 8'h01, lat, busy_ok);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL add_latency got=%0d required 1", lat);
        end
        checks++;
        if (Result !== 8'h80 || Overflow !== 1'b1 || Zero !== 1'b0 || Illegal !== 1'b0) begin
            failures++;
            $display("FAIL add_result Result=%h V=%b Z=%b I=%b required 80/1/0/0", Result, Overflow, Zero, Illegal);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_handoff out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub_cmp();
        int lat;
        bit busy_ok;
        out_ready = 1'b1;
        issue(4'b0110, 8'h05, 8'h05, lat, busy_ok);
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b1 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_result Result=%h Z=%b V=%b required 00/1/0", Result, Zero, Overflow);
        end
        issue(4'b0111, 8'hFF, 8'h01, lat, busy_ok);
        checks++;
        if (Result !== 8'h01 || Zero !== 1'b0 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL slt_result Result=%h Z=%b V=%b required 01/0/0", Result, Zero, Overflow);
        end
        issue(4'b0011, 8'hFF, 8'h01, lat, busy_ok);
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b1 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL sltu_result Result=%h Z=%b V=%b required 00/1/0", Result, Zero, Overflow);
        end
        issue(4'b0110, 8'h80, 8'h01, lat, busy_ok);
        checks++;
        if (Result !== 8'h7F || Overflow !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf Result=%h V=%b required 7F/1", Result, Overflow);
        end
        issue(4'b0001, 8'hA0, 8'h05, lat, busy_ok);
        checks++;
        if (Result !== 8'hA5 || Overflow !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL or_result Result=%h V=%b lat=%0d required A5/0/1", Result, Overflow, lat);
        end
    endtask

    task automatic test_mul();
        int lat;
        bit busy_ok;
        out_ready = 1'b1;
        issue(4'b1000, 8'h0D, 8'h0B, lat, busy_ok);
`ifdef ALU_MUL_EN
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL mul_latency got=%0d required 9", lat);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy in_ready went high during MUL, required low");
        end
        checks++;
        if (Result !== 8'h8F || Illegal !== 1'b0 || Overflow !== 1'b0 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL mul_result Result=%h I=%b V=%b Z=%b required 8F/0/0/0", Result, Illegal, Overflow, Zero);
        end
`else
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL mul_latency got=%0d required 1", lat);
        end
        checks++;
        if (Result !== 8'h00 || Illegal !== 1'b1 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL mul_illegal Result=%h I=%b Z=%b required 00/1/1", Result, Illegal, Zero);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        bit busy_ok;
        bit held_ok;
        out_ready = 1'b0;
        issue(4'b0000, 8'hF0, 8'h3C, lat, busy_ok);
        checks++;
        if (Result !== 8'h30 || lat != 1) begin
            failures++;
            $display("FAIL bp_result Result=%h lat=%0d required 30/1", Result, lat);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ALUctr   = 4'b0010;
            A        = 8'h11;
            B        = 8'h22;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (Result !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) held_ok = 1'b0;
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold Result=%h out_valid=%b in_ready=%b required 30/1/0 for 5 cycles", Result, out_valid, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== 8'h30) begin
            failures++;
            $display("FAIL bp_handoff out_valid=%b in_ready=%b Result=%h required 0/1/30", out_valid, in_ready, Result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored out_valid=%b required 0 (held request must not be accepted)", out_valid);
        end
    endtask

    task automatic test_illegal();
        int lat;
        bit busy_ok;
        out_ready = 1'b1;
        issue(4'b1111, 8'h12, 8'h34, lat, busy_ok);
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b1 || Illegal !== 1'b1 || Overflow !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL illegal_op Result=%h Z=%b I=%b V=%b lat=%0d required 00/1/1/0/1", Result, Zero, Illegal, Overflow, lat);
        end
        issue(4'b0010, 8'h03, 8'h04, lat, busy_ok);
        checks++;
        if (Result !== 8'h07 || Illegal !== 1'b0 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL after_illegal Result=%h I=%b Z=%b required 07/0/0", Result, Illegal, Zero);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        ALUctr    = 4'b1000;
        A         = 8'h0D;
        B         = 8'h0B;
`else
        out_ready = 1'b0;
        ALUctr    = 4'b0001;
        A         = 8'h0F;
        B         = 8'h30;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b0 || Overflow !== 1'b0 || Illegal !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out Result=%h Z=%b V=%b I=%b required 00/0/0/0", Result, Zero, Overflow, Illegal);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busy_ok;
        out_ready = 1'b1;
        issue(4'b0000, 8'hAA, 8'h0F, lat, busy_ok);
        checks++;
        if (Result !== 8'h0A) begin
            failures++;
            $display("FAIL b2b_first Result=%h required 0A", Result);
        end
        issue(4'b0010, 8'hFF, 8'h01, lat, busy_ok);
        checks++;
        if (Result !== 8'h00 || Zero !== 1'b1 || Overflow !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL b2b_second Result=%h Z=%b V=%b lat=%0d required 00/1/0/1", Result, Zero, Overflow, lat);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUctr    = 4'b0000;
        A         = '0;
        B         = '0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the 3-bit ALU control decoder.
- Decodes a 4-bit ALUctr into the SUBctr/OPctr/OVctr/SIGctr control set and executes the operation on WIDTH-bit operands.
- Single-cycle ops complete in one cycle. Optional multiply is iterative shift-add, taking WIDTH cycles.
- Sits between the datapath register read stage and writeback; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; not to be overridden).

Ports:
- clk        input   1      clock, rising edge
- rst        input   1      synchronous active-high reset
- in_valid   input   1      operation request valid
- in_ready   output  1      unit can accept a request
- ALUctr     input   4      opcode, sampled on accept
- A          input   WIDTH  operand A
- B          input   WIDTH  operand B
- out_valid  output  1      result valid
- out_ready  input   1      consumer accepts result
- Result     output  WIDTH  result
- Zero       output  1      Result == 0
- Overflow   output  1      signed overflow (ADD/SUB only, else 0)
- Illegal    output  1      opcode not supported

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Opcodes (ALUctr):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 0011 SLTU (unsigned)
  - 1000 MUL (low WIDTH bits of A*B)
  - all others illegal
- Decode, per opcode bits:
  - SUBctr = ALUctr[2] | (ALUctr==0011).
  - OPctr = ALUctr[1:0]; opcode 0011 maps to OPctr=11 (compare path).
  - OVctr = ALUctr[1] & ~ALUctr[0] & ~ALUctr[3].
  - SIGctr = ALUctr[2] & ALUctr[0].
- FSM states IDLE, MUL, DONE. Reset enters IDLE and clears all outputs (out_valid=0, Result=0, Zero=0, Overflow=0, Illegal=0); in_ready=1 after reset.
- IDLE:
  - in_ready=1.
  - On in_valid, latch ALUctr/A/B.
  - Non-MUL op: compute combinationally, register Result and flags, go to DONE. Latency 1 cycle (out_valid high the cycle after accept).
  - MUL: clear accumulator, load multiplicand/multiplier, counter=0, go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations, go to DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - out_valid=1 and in_ready=0; Result and flags held stable until out_ready.
  - On out_ready, go to IDLE, out_valid=0 next cycle.
  - No accept in the same cycle as result handoff (max throughput 1 op / 2 cycles).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow = (A[msb]==B'[msb]) & (R[msb]!=A[msb]), where B' = ~B+1 for SUB.
  - SLT/SLTU: Result = {WIDTH-1 zeros, lt}. Signed lt uses difference sign XOR overflow; unsigned lt uses borrow out.
  - Overflow is 0 for SLT/SLTU/logic/MUL.
- Illegal opcode: completes like a single-cycle op with Result=0, Zero=1, Illegal=1.
- Reset mid-operation (MUL or DONE): abort, return to IDLE; the pending result is discarded.
- in_valid while in_ready=0 is ignored. The producer must hold its request.

Optional Feature:
- ALU_MUL_EN defined: MUL opcode 1000 is supported via the MUL state.
- ALU_MUL_EN undefined: MUL state and multiply registers are not compiled. Opcode 1000 is treated as illegal (Result=0, Illegal=1, latency 1).

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_MUL)
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DONE)
  - OPctr select encoding
- One sub-module: alu_ctrl_dec, a purely combinational opcode -> {SUBctr, OPctr, OVctr, SIGctr, illegal} decoder, instantiated once.

Test Plan (WIDTH=8):
- ADD A=0x7F B=0x01, out_ready=1 -> Result=0x80, Overflow=1, Zero=0, out_valid 1 cycle after accept.
- SUB A=0x05 B=0x05 -> Result=0x00, Zero=1, Overflow=0; SLT A=0xFF B=0x01 -> Result=0x01; SLTU same operands -> Result=0x00.
- MUL A=0x0D B=0x0B with ALU_MUL_EN -> Result=0x8F, out_valid 9 cycles after accept, in_ready=0 throughout. Without macro -> Illegal=1, Result=0.
- Backpressure: out_ready=0 for 5 cycles after AND A=0xF0 B=0x3C -> Result=0x30 held stable, in_ready=0, new in_valid ignored; handoff when out_ready=1.
- Opcode 1111 -> Result=0, Zero=1, Illegal=1; next op behaves normally.
- rst asserted 3 cycles into MUL -> next cycle IDLE, out_valid=0, all outputs 0, in_ready=1.
